// File: rtl/qspi_flash_emu.sv
// qspi_flash_emu: oversampling SPI/QSPI flash emulator on the system clock.
// Reads 0x03/0x0B/0xEB (with XIP), power-down 0xB9/0xAB, byte load port.
//
// Ports:
//   clk, resetn             system clock, async active-low reset
//   flash_clk, flash_csb    SPI mode-0 clock and chip select from host
//   flash_io_di/do/oe       quad pad inputs, output values, output enables
//   load_en/addr/data       host preload port, one byte per cycle
//   busy                    synchronised chip select is low
//   powered_down            deep power-down active
//   cmd_err                 one-cycle pulse on an unknown/rejected opcode
module qspi_flash_emu #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_BITS  = 24,
  parameter int DUMMY_FAST = 8,
  parameter int DUMMY_QUAD = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flash_clk,
  input  logic          flash_csb,
  input  logic [3:0]    flash_io_di,
  output logic [3:0]    flash_io_do,
  output logic [3:0]    flash_io_oe,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          busy,
  output logic          powered_down,
  output logic          cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_MODE,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  localparam logic [7:0] A_END_S = 8'(ADDR_BITS - 1);
  localparam logic [7:0] A_END_Q = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] D_END_F = 8'(DUMMY_FAST - 1);
  localparam logic [7:0] D_END_Q = 8'(DUMMY_QUAD - 1);

  logic [7:0] mem_q [DEPTH];

  logic                 sck_s1_q, sck_s2_q, sck_s3_q;
  logic                 csb_s1_q, csb_s2_q, csb_s3_q;
  logic [3:0]           io_s1_q, io_s2_q;
  logic [1:0]           vld_q, vld_d;
  logic                 armed_q, armed_d;
  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] sreg_q, sreg_d;
  logic                 quad_q, quad_d;
  logic                 fast_q, fast_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [7:0]           obuf_q, obuf_d;
  logic [3:0]           do_q, do_d;
  logic [3:0]           oe_q, oe_d;
  logic                 err_q, err_d;
  logic                 pd_q, pd_d;
  logic                 pd_set_q, pd_set_d;
  logic                 pd_clr_q, pd_clr_d;
  logic                 xip_q, xip_d;

  logic                 sck_rise, sck_fall;
  logic                 csb_rise, csb_fall;
  logic [ADDR_BITS-1:0] sh1, sh4, shin;
  logic [7:0]           cmd;
  logic                 fetch;
  logic [AW-1:0]        fetch_idx;

  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    sck_rise = sck_s2_q & ~sck_s3_q;
    sck_fall = ~sck_s2_q & sck_s3_q;
    csb_rise = csb_s2_q & ~csb_s3_q;
    // After reset the synchroniser holds csb high artificially;
    // only a low seen after a genuine high starts a frame.
    csb_fall = ~csb_s2_q & csb_s3_q & armed_q;
    sh1  = (sreg_q << 1) | ADDR_BITS'(io_s2_q[0]);
    sh4  = (sreg_q << 4) | ADDR_BITS'(io_s2_q);
    shin = quad_q ? sh4 : sh1;
    cmd  = sh1[7:0];
  end

  always_comb begin
    vld_d     = {vld_q[0], 1'b1};
    armed_d   = armed_q | (vld_q[1] & csb_s2_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    quad_d    = quad_q;
    fast_d    = fast_q;
    ptr_d     = ptr_q;
    obuf_d    = obuf_q;
    do_d      = do_q;
    oe_d      = oe_q;
    err_d     = 1'b0;
    pd_d      = pd_q;
    pd_set_d  = pd_set_q;
    pd_clr_d  = pd_clr_q;
    xip_d     = xip_q;
    fetch     = 1'b0;
    fetch_idx = ptr_q;

    if (csb_rise) begin
      state_d  = S_IDLE;
      do_d     = 4'h0;
      oe_d     = 4'h0;
      pd_set_d = 1'b0;
      pd_clr_d = 1'b0;
      if (pd_set_q) pd_d = 1'b1;
      if (pd_clr_q) pd_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (csb_fall) begin
            cnt_d  = '0;
            sreg_d = '0;
            fast_d = 1'b0;
            if (xip_q) begin
              state_d = S_ADDR;
              quad_d  = 1'b1;
            end else begin
              state_d = S_CMD;
              quad_d  = 1'b0;
            end
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sreg_d = sh1;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d   = '0;
              state_d = S_IGNORE;
              if (pd_q && cmd != 8'hAB) begin
                err_d = 1'b1;
              end else begin
                unique case (1'b1)
                  (cmd == 8'h03): state_d = S_ADDR;
                  (cmd == 8'h0B): begin
                    state_d = S_ADDR;
                    fast_d  = 1'b1;
                  end
                  (cmd == 8'hEB): begin
                    state_d = S_ADDR;
                    quad_d  = 1'b1;
                  end
                  (cmd == 8'hB9): pd_set_d = 1'b1;
                  (cmd == 8'hAB): pd_clr_d = 1'b1;
                  default: err_d = 1'b1;
                endcase
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sreg_d = shin;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == (quad_q ? A_END_Q : A_END_S)) begin
              cnt_d = '0;
              ptr_d = shin[AW-1:0];
              if (quad_q) begin
                state_d = S_MODE;
              end else if (fast_q && DUMMY_FAST > 0) begin
                state_d = S_DUMMY;
              end else begin
                fetch     = 1'b1;
                fetch_idx = shin[AW-1:0];
              end
            end
          end
        end
        S_MODE: begin
          if (sck_rise) begin
            sreg_d = sh4;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin
              cnt_d = '0;
              xip_d = (sh4[5:4] == 2'b10);
              if (DUMMY_QUAD > 0) state_d = S_DUMMY;
              else fetch = 1'b1;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == (quad_q ? D_END_Q : D_END_F)) fetch = 1'b1;
          end
        end
        S_DATA: begin
          if (sck_fall) begin
            if (quad_q) begin
              do_d   = obuf_q[7:4];
              obuf_d = obuf_q << 4;
              oe_d   = 4'b1111;
            end else begin
              do_d   = {2'b00, obuf_q[7], 1'b0};
              obuf_d = obuf_q << 1;
              oe_d   = 4'b0010;
            end
          end
          if (sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == (quad_q ? 8'd1 : 8'd7)) fetch = 1'b1;
          end
        end
        S_IGNORE: ;
      endcase

      // A concurrent load to fetch_idx is not visible here:
      // the array read sees the pre-write contents.
      if (fetch) begin
        state_d = S_DATA;
        cnt_d   = '0;
        obuf_d  = mem_q[fetch_idx];
        ptr_d   = fetch_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      csb_s1_q <= 1'b1;
      csb_s2_q <= 1'b1;
      csb_s3_q <= 1'b1;
      io_s1_q  <= 4'h0;
      io_s2_q  <= 4'h0;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      quad_q   <= 1'b0;
      fast_q   <= 1'b0;
      ptr_q    <= '0;
      obuf_q   <= '0;
      do_q     <= 4'h0;
      oe_q     <= 4'h0;
      err_q    <= 1'b0;
      pd_q     <= 1'b0;
      pd_set_q <= 1'b0;
      pd_clr_q <= 1'b0;
      xip_q    <= 1'b0;
    end else begin
      sck_s1_q <= flash_clk;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      csb_s1_q <= flash_csb;
      csb_s2_q <= csb_s1_q;
      csb_s3_q <= csb_s2_q;
      io_s1_q  <= flash_io_di;
      io_s2_q  <= io_s1_q;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      quad_q   <= quad_d;
      fast_q   <= fast_d;
      ptr_q    <= ptr_d;
      obuf_q   <= obuf_d;
      do_q     <= do_d;
      oe_q     <= oe_d;
      err_q    <= err_d;
      pd_q     <= pd_d;
      pd_set_q <= pd_set_d;
      pd_clr_q <= pd_clr_d;
      xip_q    <= xip_d;
    end
  end

  assign flash_io_do  = do_q;
  assign flash_io_oe  = oe_q;
  assign busy         = ~csb_s2_q;
  assign powered_down = pd_q;
  assign cmd_err      = err_q;

endmodule

// File: tb/tb_qspi_flash_emu.sv
// tb_qspi_flash_emu: randomized bench for qspi_flash_emu.
// Host SPI driver plus a byte-array flash model with pd/xip flags.
module tb_qspi_flash_emu;

  localparam int DEPTH = 256;
  localparam int HP    = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flash_clk = 1'b0;
  logic       flash_csb = 1'b1;
  logic [3:0] flash_io_di = 4'h0;
  logic [3:0] flash_io_do, flash_io_oe;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h0;
  logic [7:0] load_data = 8'h0;
  logic       busy, powered_down, cmd_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_cnt = 0;
  int err_at = -1;

  byte unsigned mem_m [DEPTH];
  bit xip_m = 0;
  bit pd_m = 0;

  qspi_flash_emu #(
    .DEPTH(DEPTH), .ADDR_BITS(24),
    .DUMMY_FAST(8), .DUMMY_QUAD(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .flash_clk(flash_clk), .flash_csb(flash_csb),
    .flash_io_di(flash_io_di),
    .flash_io_do(flash_io_do),
    .flash_io_oe(flash_io_oe),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data),
    .busy(busy), .powered_down(powered_down),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cmd_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_at  <= cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = v;
    @(negedge clk);
    load_en = 1'b0;
    mem_m[a] = v;
  endtask

  // One SPI clock: drive io, rise (sample DUT), fall.
  // inj pulses load_en in the cycle the DUT acts on this rise.
  task automatic sck(input logic [3:0] drv, input bit inj,
                     output logic [3:0] q_do,
                     output logic [3:0] q_oe,
                     output int rc);
    flash_io_di = drv;
    repeat (HP) @(negedge clk);
    flash_clk = 1'b1;
    q_do = flash_io_do;
    q_oe = flash_io_oe;
    rc = cyc;
    if (inj) begin
      repeat (2) @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      repeat (HP - 3) @(negedge clk);
    end else begin
      repeat (HP) @(negedge clk);
    end
    flash_clk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] op, input logic [23:0] addr,
                       input logic [7:0] mode, input int n,
                       input bit inj);
    logic [3:0] d, o;
    logic [3:0] pre[$];
    logic [7:0] b;
    int rc, cmd_rc, e0, bad_pre, bad_dat, ia;
    bit quad, fast, rd, err_exp, xip0;
    quad = 0; fast = 0; rd = 0; err_exp = 0;
    bad_pre = 0; bad_dat = 0; cmd_rc = 0;
    e0 = err_cnt;
    xip0 = xip_m;
    flash_csb = 1'b0;
    repeat (HP) @(negedge clk);
    check("busy", busy, 1);
    if (xip0) begin
      quad = 1; rd = 1;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sck({3'b000, op[i]}, 0, d, o, rc);
        if (o !== 4'h0) bad_pre++;
      end
      cmd_rc = rc;
      if (pd_m && op != 8'hAB) err_exp = 1;
      else begin
        case (op)
          8'h03: rd = 1;
          8'h0B: begin rd = 1; fast = 1; end
          8'hEB: begin rd = 1; quad = 1; end
          8'hB9, 8'hAB: ;
          default: err_exp = 1;
        endcase
      end
    end
    if (rd) begin
      if (quad) begin
        for (int i = 5; i >= 0; i--) pre.push_back(addr[i*4 +: 4]);
        pre.push_back(mode[7:4]);
        pre.push_back(mode[3:0]);
        repeat (4) pre.push_back(4'($urandom));
      end else begin
        for (int i = 23; i >= 0; i--) pre.push_back({3'b000, addr[i]});
        if (fast) repeat (8) pre.push_back(4'($urandom));
      end
      foreach (pre[k]) begin
        sck(pre[k], inj && (k == pre.size() - 1), d, o, rc);
        if (o !== 4'h0) bad_pre++;
      end
      ia = int'(addr[7:0]);
      for (int j = 0; j < n; j++) begin
        b = 8'h0;
        for (int c = 0; c < (quad ? 2 : 8); c++) begin
          sck(4'h0, 0, d, o, rc);
          if (quad) b = {b[3:0], d};
          else b = {b[6:0], d[1]};
          if (o !== (quad ? 4'hF : 4'h2)) bad_dat++;
        end
        check($sformatf("rd[%0d]@%0h", j, (ia + j) % DEPTH),
              b, mem_m[(ia + j) % DEPTH]);
      end
      check("data_oe_bad", bad_dat, 0);
      if (quad) xip_m = (mode[5:4] == 2'b10);
    end else begin
      repeat (8) begin
        sck(4'($urandom), 0, d, o, rc);
        if (o !== 4'h0) bad_pre++;
      end
    end
    check("pre_oe_bad", bad_pre, 0);
    repeat (HP) @(negedge clk);
    flash_csb = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_after_csb", flash_io_oe, 4'h0);
    repeat (2 * HP) @(negedge clk);
    check("err_count", err_cnt - e0, err_exp);
    if (err_exp) check("err_timing", err_at - cmd_rc, 3);
    if (!xip0 && !err_exp) begin
      if (op == 8'hB9) pd_m = 1;
      if (op == 8'hAB) pd_m = 0;
    end
    check("powered_down", powered_down, pd_m);
  endtask

  logic [3:0] d, o;
  int rc, bad;
  logic [7:0] op03 = 8'h03;
  logic [23:0] a24;
  logic [7:0] ops [4] = '{8'h03, 8'h0B, 8'hEB, 8'h5A};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_do", flash_io_do, 0);
    check("rst_oe", flash_io_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_pd", powered_down, 0);
    check("rst_err", cmd_err, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < DEPTH; i++) load(8'(i), 8'(i));

    frame(8'h03, 24'h000010, 8'h00, 4, 0);
    frame(8'h0B, 24'h0000FE, 8'h00, 3, 0);
    frame(8'hEB, 24'h000020, 8'hA0, 3, 0);
    check("xip_set", xip_m, 1);
    frame(8'h00, 24'h000040, 8'h00, 1, 0);
    frame(8'h03, 24'h000030, 8'h00, 1, 0);

    frame(8'hB9, 24'h0, 8'h00, 0, 0);
    frame(8'h03, 24'h0, 8'h00, 1, 0);
    frame(8'hAB, 24'h0, 8'h00, 0, 0);
    frame(8'h03, 24'h0, 8'h00, 1, 0);

    // Abort after four address bits.
    flash_csb = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 7; i >= 0; i--) sck({3'b000, op03[i]}, 0, d, o, rc);
    repeat (4) sck(4'h0, 0, d, o, rc);
    flash_csb = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_oe", flash_io_oe, 0);
    repeat (2 * HP) @(negedge clk);
    frame(8'h03, 24'h000005, 8'h00, 1, 0);

    // Load collides with the first fetch: old value returned.
    load_addr = 8'h50;
    load_data = 8'hA5;
    frame(8'h03, 24'h000050, 8'h00, 1, 1);
    mem_m[8'h50] = 8'hA5;
    frame(8'h03, 24'h000050, 8'h00, 1, 0);

    // Reset in the middle of a data phase.
    flash_csb = 1'b0;
    repeat (HP) @(negedge clk);
    a24 = 24'h000060;
    for (int i = 7; i >= 0; i--) sck({3'b000, op03[i]}, 0, d, o, rc);
    for (int i = 23; i >= 0; i--) sck({3'b000, a24[i]}, 0, d, o, rc);
    repeat (3) sck(4'h0, 0, d, o, rc);
    check("pre_rst_oe", o, 4'h2);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_async_oe", flash_io_oe, 0);
    check("rst_async_do", flash_io_do, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    bad = 0;
    repeat (10) begin
      sck(4'($urandom), 0, d, o, rc);
      if (o !== 4'h0) bad++;
    end
    check("no_resume_oe", bad, 0);
    flash_csb = 1'b1;
    repeat (4 * HP) @(negedge clk);
    xip_m = 0;
    pd_m = 0;
    frame(8'h03, 24'h000061, 8'h00, 2, 0);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) load(8'($urandom), 8'($urandom));
      frame(ops[$urandom_range(0, 3)], 24'($urandom),
            8'($urandom), $urandom_range(1, 4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_flash_emu.md
# qspi_flash_emu

Synthesizable, oversampling SPI/QSPI flash emulator for the controller SoC and its simulation benches. It replaces the behavioural flash model with a block that runs on the system clock and sits on the flash_* pins of the SoC. It presents a DEPTH-byte memory, preloaded through a host load port, and answers standard, fast and quad-I/O read commands. Continuous-read (XIP) mode and deep power-down are supported.

## Interface
- DEPTH, 4096: memory size in bytes; power of two, ≥ 256.
- ADDR_BITS, 24: address bits received per command.
- DUMMY_FAST, 8: dummy SPI clocks for 0x0B.
- DUMMY_QUAD, 4: dummy SPI clocks for 0xEB, after the mode byte.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- flash_clk  in  1  SPI clock from host, mode 0.
- flash_csb  in  1  chip select, active low.
- flash_io_di  in  4  pad inputs io3..io0.
- flash_io_do  out  4  pad output values.
- flash_io_oe  out  4  pad output enables.
- load_en  in  1  write one byte into memory this cycle.
- load_addr  in  log2(DEPTH)  load byte address.
- load_data  in  8  load byte.
- busy  out  1  flash_csb, after synchronisation, is low.
- powered_down  out  1  deep power-down is active.
- cmd_err  out  1  one-cycle pulse on an unrecognised or rejected command.

## Operation
- flash_clk, flash_csb and flash_io_di each pass through a 2-flop synchroniser.
- Edges are detected on the synchronised flash_clk:
  - rising edge: sample inputs.
  - falling edge: shift out the next output bit(s).
- Host SPI clock half-period must be ≥ 4 clk.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- IDLE:
  - synced csb falling → CMD.
  - If xip=1, synced csb falling → ADDR instead, with quad width.
- CMD: 8 bits MSB-first on io0. Decode:
  - 0x03 → ADDR single, then DATA single, no dummy.
  - 0x0B → ADDR single, then DUMMY (DUMMY_FAST), then DATA single.
  - 0xEB → ADDR quad (ADDR_BITS/4 clocks), then MODE, then DUMMY (DUMMY_QUAD), then DATA quad.
  - 0xB9 → sets powered_down at csb rise; then IGNORE.
  - 0xAB → clears powered_down at csb rise; then IGNORE.
  - While powered_down=1, any command except 0xAB → IGNORE and pulse cmd_err.
  - Unknown opcode → IGNORE and pulse cmd_err.
- MODE: 2 quad clocks carry the mode byte. xip ← (mode[5:4]==2'b10), evaluated at MODE end.
- Memory index = address[log2(DEPTH)-1:0]; upper address bits are ignored (aliasing).
- DATA:
  - Byte fetched on the sample edge that completes the previous phase, then at every byte boundary.
  - Address increments after each byte and wraps DEPTH-1 → 0.
  - Single mode drives io1 only, MSB first: oe=4'b0010.
  - Quad mode drives io3..0 high nibble first: oe=4'b1111.
- Output drive: first bit is driven on the falling edge after the last ADDR/DUMMY rising edge. oe stays asserted until csb rises.
- csb rising in any state → IDLE, oe=0, do=0. Partial commands are discarded; xip and powered_down are kept.
- Load port works in any state, including mid-transaction. A load to the byte being fetched in the same cycle loses: the fetch returns the old value, and the load still commits.

## Timing
- Reset values: flash_io_do=0, flash_io_oe=0, busy=0, powered_down=0, cmd_err=0, xip=0, FSM=IDLE. Memory contents are not reset.
- Pin edge → internal action: 3 clk (2 synchroniser + 1 register). flash_io_do/oe update 3 clk after a flash_clk falling edge at the pin.
- csb rising at pin → oe=0 within 3 clk.
- Loaded byte is readable from the next cycle.
- cmd_err is high exactly 1 clk, 3 clk after the 8th CMD rising edge.
- Reset asserted mid-transaction: outputs are cleared immediately (asynchronously). The FSM resumes only at the next csb falling edge after reset release.

## Test plan
- Load 0x00..0xFF into addresses 0..255. Send 0x03, address 0x000010, read 4 bytes → io1 returns 10 11 12 13. oe=4'b0010 during data only.
- Send 0x0B, address 0x0000FE, 8 dummy clocks, read 3 bytes → FE FF 00. With DEPTH=256 the address wraps, so the third byte is address 0's value (0x00).
- Send 0xEB, address 0x000020, mode 0xA0, 4 dummy clocks → nibbles 2,0,2,1,2,2 and oe=4'b1111. Next csb frame sends only address 0x000040 plus mode 0x00 → returns 0x40. xip then clears, so the following frame needs a full opcode.
- Send 0xB9, then 0x03 → cmd_err pulses, io stays tristated. Then send 0xAB, then 0x03 at address 0 → 0x00 returned.
- Raise csb after 4 address bits of 0x03 → oe=0 within 3 clk. A following full 0x03 read at address 0x05 → 0x05.
- Write load_data=0xA5 to the byte currently being fetched, in the fetch cycle → that read returns the old value. A re-read returns 0xA5. Assert resetn=0 mid-DATA → oe=0 in the same cycle.
